// File: rtl/pcie_sram_port_arbiter_pkg.sv
// rtl/pcie_sram_port_arbiter_pkg.sv - shared types and sizes for the PCIe SRAM port arbiter
package pcie_sram_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam int SRAM_AW = 10;
    localparam int SRAM_DW = 256;

    // Width of a client index; a single client still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_sram_port_arbiter_if.sv
// rtl/pcie_sram_port_arbiter_if.sv - client-side request/grant/read-return bus
interface pcie_sram_port_arbiter_if
    import pcie_sram_arb_pkg::*;
#(
    parameter int NC = 3,
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW
);
    logic [NC-1:0]    req;
    logic [NC-1:0]    we;
    logic [NC-1:0]    lock;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC-1:0]    gnt;
    logic [NC-1:0]    rvalid;
    logic [DW-1:0]    rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/pcie_sram_port_arbiter_rr_pick.sv
// rtl/pcie_sram_port_arbiter_rr_pick.sv - rotate-priority pick of the first request at or after ptr
module pcie_rr_pick
    import pcie_sram_arb_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcie_sram_port_arbiter.sv
// rtl/pcie_sram_port_arbiter.sv - single-port SRAM arbiter: round-robin, burst lock with timeout, read steering
module pcie_sram_port_arbiter
    import pcie_sram_arb_pkg::*;
#(
    parameter  int NUM_CLIENTS  = 3,
    parameter  int AW           = SRAM_AW,
    parameter  int DW           = SRAM_DW,
    parameter  int LOCK_TIMEOUT = 64,
    localparam int IW           = idx_w(NUM_CLIENTS),
    localparam int CW           = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pcie_sram_port_arbiter_if.slave bus,
    output logic                   sram_ren,
    output logic                   sram_wen,
    output logic [AW-1:0]          sram_addr,
    output logic [DW-1:0]          sram_wdata,
    input  logic [DW-1:0]          sram_rdata,
    output logic                   lock_timeout,
    output logic [IW-1:0]          owner
);
    arb_state_e             state;
    logic [IW-1:0]          rr_ptr;
    logic [CW-1:0]          lock_cnt;
    logic [NUM_CLIENTS-1:0] blocked;
    logic [NUM_CLIENTS-1:0] rvalid_q;

    logic [NUM_CLIENTS-1:0] pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic [NUM_CLIENTS-1:0] gnt_c;
    logic [IW-1:0]          sel;
    logic                   grant_any;
    logic                   timeout_hit;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (int'(i) == NUM_CLIENTS - 1) ? '0 : i + 1'b1;
    endfunction

    pcie_rr_pick #(.N(NUM_CLIENTS)) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant is combinational so the SRAM sees the access in the request cycle.
    always_comb begin
        gnt_c = '0;
        sel   = (state == ARB_OWNED) ? owner : pick_idx;
        if (rst_n) begin
            if (state == ARB_IDLE)
                gnt_c = pick_oh;
            else if (bus.req[owner])
                gnt_c[owner] = 1'b1;
        end
    end

    assign grant_any   = |gnt_c;
    assign sram_ren    = grant_any & ~bus.we[sel];
    assign sram_wen    = grant_any &  bus.we[sel];
    assign sram_addr   = bus.addr[int'(sel)*AW +: AW];
    assign sram_wdata  = bus.wdata[int'(sel)*DW +: DW];
    assign timeout_hit = (LOCK_TIMEOUT != 0) && (lock_cnt == CW'(LOCK_TIMEOUT - 1));

    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = sram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lock_cnt     <= '0;
            blocked      <= '0;
            rvalid_q     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            rvalid_q     <= gnt_c & ~bus.we;
            lock_timeout <= 1'b0;
            // A timed-out client regains lock rights only after dropping lock.
            blocked      <= blocked & bus.lock;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        if (bus.lock[pick_idx] && !blocked[pick_idx]) begin
                            state    <= ARB_OWNED;
                            owner    <= pick_idx;
                            lock_cnt <= '0;
                        end else begin
                            rr_ptr <= nxt(pick_idx);
                        end
                    end
                end
                ARB_OWNED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (!bus.lock[owner]) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= nxt(owner);
                        owner  <= '0;
                    end else if (timeout_hit) begin
                        state          <= ARB_IDLE;
                        rr_ptr         <= nxt(owner);
                        owner          <= '0;
                        blocked[owner] <= 1'b1;
                        lock_timeout   <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_sram_port_arbiter.sv
// tb/tb_pcie_sram_port_arbiter.sv - directed bench with a per-cycle arbitration model
module tb_pcie_sram_port_arbiter;
    localparam int NC = 3;
    localparam int AW = 10;
    localparam int DW = 256;
    localparam int LT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcie_sram_port_arbiter_if #(.NC(NC), .AW(AW), .DW(DW)) bus ();

    logic          sram_ren, sram_wen, lock_timeout;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [1:0]    owner;

    pcie_sram_port_arbiter #(.NUM_CLIENTS(NC), .AW(AW), .DW(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sram_ren     (sram_ren),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .lock_timeout (lock_timeout),
        .owner        (owner)
    );

    logic [DW-1:0] mem   [0:1023];
    logic [DW-1:0] m_mem [0:1023];

    always @(posedge clk) begin
        if (sram_wen) mem[sram_addr] <= sram_wdata;
        if (sram_ren) sram_rdata <= mem[sram_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model state: lock holder (-1 when free), next RR start, lock age, blocked clients.
    int           m_own = -1;
    int           m_rr  = 0;
    int           m_cnt = 0;
    bit [NC-1:0]  m_blk = '0;
    bit [NC-1:0]  m_rv  = '0;
    bit           m_to  = 1'b0;
    logic [DW-1:0] m_rd = '0;

    always @(negedge clk) begin
        int eg;
        logic [AW-1:0] a;
        logic [NC-1:0] eoh;
        if (!rst_n) begin
            m_own = -1; m_rr = 0; m_cnt = 0; m_blk = '0; m_rv = '0; m_to = 1'b0;
            chk("rst_gnt", 256'(bus.gnt), 256'(0));
            chk("rst_ren", 256'(sram_ren), 256'(0));
            chk("rst_wen", 256'(sram_wen), 256'(0));
            chk("rst_rvalid", 256'(bus.rvalid), 256'(0));
            chk("rst_timeout", 256'(lock_timeout), 256'(0));
            chk("rst_owner", 256'(owner), 256'(0));
        end else begin
            eg = -1;
            if (m_own < 0) begin
                for (int k = 0; k < NC; k++)
                    if (eg < 0 && bus.req[(m_rr + k) % NC]) eg = (m_rr + k) % NC;
            end else if (bus.req[m_own]) begin
                eg = m_own;
            end
            eoh = '0;
            if (eg >= 0) eoh[eg] = 1'b1;
            chk("gnt", 256'(bus.gnt), 256'(eoh));
            chk("ren", 256'(sram_ren), 256'(eg >= 0 && !bus.we[eg]));
            chk("wen", 256'(sram_wen), 256'(eg >= 0 && bus.we[eg]));
            a = '0;
            if (eg >= 0) begin
                a = bus.addr[eg*AW +: AW];
                chk("addr", 256'(sram_addr), 256'(a));
                if (bus.we[eg]) chk("wdata", sram_wdata, bus.wdata[eg*DW +: DW]);
            end
            chk("rvalid", 256'(bus.rvalid), 256'(m_rv));
            if (m_rv != 0) chk("rdata", bus.rdata, m_rd);
            chk("lock_timeout", 256'(lock_timeout), 256'(m_to));
            chk("owner", 256'(owner), 256'((m_own < 0) ? 0 : m_own));

            m_rv = '0;
            m_to = 1'b0;
            if (eg >= 0) begin
                if (bus.we[eg]) m_mem[a] = bus.wdata[eg*DW +: DW];
                else begin m_rv = eoh; m_rd = m_mem[a]; end
            end
            for (int i = 0; i < NC; i++) if (!bus.lock[i]) m_blk[i] = 1'b0;
            if (m_own < 0) begin
                if (eg >= 0) begin
                    if (bus.lock[eg] && !m_blk[eg]) begin m_own = eg; m_cnt = 0; end
                    else m_rr = (eg + 1) % NC;
                end
            end else if (!bus.lock[m_own]) begin
                m_rr = (m_own + 1) % NC; m_own = -1;
            end else if (m_cnt == LT - 1) begin
                m_to = 1'b1; m_blk[m_own] = 1'b1; m_rr = (m_own + 1) % NC; m_own = -1;
            end else begin
                m_cnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic [NC-1:0] r, input logic [NC-1:0] w, input logic [NC-1:0] l);
        bus.req = r; bus.we = w; bus.lock = l;
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        bus.addr[c*AW +: AW] = a;
    endtask

    task automatic set_wdata(input int c, input logic [DW-1:0] d);
        bus.wdata[c*DW +: DW] = d;
    endtask

    logic [NC-1:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [DW-1:0] w1  = {8{32'h1234_5678}};
    logic [DW-1:0] a5  = {32{8'hA5}};

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]   <= {8{32'(i) ^ 32'hC0DE_0000}};
            m_mem[i]  = {8{32'(i) ^ 32'hC0DE_0000}};
        end
        bus.addr = '0; bus.wdata = '0;
        drive('0, '0, '0);
        repeat (2) cyc();
        settle();
        chk("reset_gnt", 256'(bus.gnt), 256'(0));
        chk("reset_rvalid", 256'(bus.rvalid), 256'(0));
        rst_n = 1'b1;
        cyc();

        // 1: c0 read and c2 write collide, rr starts at c0
        cyc(); set_addr(0, 10'h010); set_addr(2, 10'h020); set_wdata(2, w1); drive(3'b101, 3'b100, 3'b000); settle();
        chk("t1_gnt0", 256'(bus.gnt), 256'(3'b001));
        chk("t1_ren", 256'(sram_ren), 256'(1));
        chk("t1_addr0", 256'(sram_addr), 256'(10'h010));
        cyc(); drive(3'b100, 3'b100, 3'b000); settle();
        chk("t1_gnt1", 256'(bus.gnt), 256'(3'b100));
        chk("t1_wen", 256'(sram_wen), 256'(1));
        chk("t1_addr1", 256'(sram_addr), 256'(10'h020));
        chk("t1_rvalid", 256'(bus.rvalid), 256'(3'b001));
        chk("t1_rdata", bus.rdata, {8{32'hC0DE_0010}});
        cyc(); drive('0, '0, '0);

        // 2: all three request continuously
        cyc(); drive(3'b111, 3'b000, 3'b000);
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t2_rr_seq", 256'(bus.gnt), 256'(seq[k]));
            if (k < 5) cyc();
        end
        cyc(); drive('0, '0, '0);

        // 3: c1 locked read burst with gaps, c0 waits
        cyc(); set_addr(1, 10'h100); drive(3'b010, 3'b000, 3'b010); settle();
        chk("t3_lock_gnt", 256'(bus.gnt), 256'(3'b010));
        for (int b = 1; b < 4; b++) begin
            cyc(); set_addr(0, 10'h005); drive(3'b001, 3'b000, 3'b010); settle();
            chk("t3_c0_held", 256'(bus.gnt), 256'(3'b000));
            chk("t3_rvalid", 256'(bus.rvalid), 256'(3'b010));
            chk("t3_owner", 256'(owner), 256'(1));
            cyc(); set_addr(1, 10'(10'h100 + b)); drive(3'b011, 3'b000, (b == 3) ? 3'b000 : 3'b010); settle();
            chk("t3_beat", 256'(bus.gnt), 256'(3'b010));
        end
        cyc(); drive(3'b001, 3'b000, 3'b000); settle();
        chk("t3_c0_after", 256'(bus.gnt), 256'(3'b001));
        chk("t3_owner_free", 256'(owner), 256'(0));
        cyc(); drive('0, '0, '0); settle();
        chk("t3_c0_rvalid", 256'(bus.rvalid), 256'(3'b001));

        // 4: c0 never drops lock, timeout forces release
        cyc(); drive(3'b001, 3'b000, 3'b001); settle();
        chk("t4_lock_gnt", 256'(bus.gnt), 256'(3'b001));
        for (int k = 1; k <= LT; k++) begin
            cyc(); drive(3'b011, 3'b000, 3'b001); settle();
            chk("t4_owned_gnt", 256'(bus.gnt), 256'(3'b001));
            chk("t4_no_pulse", 256'(lock_timeout), 256'(0));
        end
        cyc(); settle();
        chk("t4_pulse", 256'(lock_timeout), 256'(1));
        chk("t4_c1_next", 256'(bus.gnt), 256'(3'b010));
        cyc(); drive(3'b001, 3'b000, 3'b001); settle();
        chk("t4_c0_plain", 256'(bus.gnt), 256'(3'b001));
        chk("t4_pulse_once", 256'(lock_timeout), 256'(0));
        cyc(); drive(3'b011, 3'b000, 3'b001); settle();
        chk("t4_not_relocked", 256'(bus.gnt), 256'(3'b010));
        cyc(); drive(3'b001, 3'b000, 3'b001); settle();
        cyc(); drive('0, '0, '0);

        // 6: write then read back the top word
        cyc(); set_addr(1, 10'h3FF); set_wdata(1, a5); drive(3'b010, 3'b010, 3'b000); settle();
        chk("t6_wr_gnt", 256'(bus.gnt), 256'(3'b010));
        cyc(); set_addr(0, 10'h3FF); drive(3'b001, 3'b000, 3'b000); settle();
        chk("t6_rd_gnt", 256'(bus.gnt), 256'(3'b001));
        cyc(); drive('0, '0, '0); settle();
        chk("t6_rvalid", 256'(bus.rvalid), 256'(3'b001));
        chk("t6_rdata", bus.rdata, a5);

        // 5: reset right after a c2 read grant
        cyc(); set_addr(2, 10'h030); drive(3'b100, 3'b000, 3'b000); settle();
        chk("t5_gnt", 256'(bus.gnt), 256'(3'b100));
        cyc(); rst_n = 1'b0; settle();
        chk("t5_rst_gnt", 256'(bus.gnt), 256'(0));
        chk("t5_rst_rvalid", 256'(bus.rvalid), 256'(0));
        cyc(); drive('0, '0, '0); settle();
        rst_n = 1'b1;
        cyc(); drive(3'b110, 3'b000, 3'b010); settle();
        chk("t5_rr_zero", 256'(bus.gnt), 256'(3'b010));
        chk("t5_no_stale_rvalid", 256'(bus.rvalid), 256'(0));
        cyc(); drive(3'b100, 3'b000, 3'b010); settle();
        chk("t5_owned", 256'(bus.gnt), 256'(3'b000));
        cyc(); drive(3'b010, 3'b000, 3'b000); settle();
        chk("t5_release", 256'(bus.gnt), 256'(3'b010));
        cyc(); drive('0, '0, '0);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
